// File: rtl/load_unit.sv
// load_unit: multi-cycle MIPS load controller.
// Issues one word-aligned read on the data-memory bus and honours wait-states.
// Selects the byte or halfword lane from the returned word, then sign- or zero-extends it.
// Holds busy until the result is returned with a one-cycle done strobe.
module load_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    // Wait counter is sized to reach MAX_WAIT. When MAX_WAIT is 0 the timeout
    // is disabled, and the counter is then free to wrap.
    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_rdata;
    logic             r_addr_err;
    logic             r_bus_err;
    logic             r_mem_read;
    logic [31:0]      r_mem_address;
    logic [3:0]       r_mem_byteenable;

    logic             w_req_ok;
    logic [3:0]       w_be;
    logic [31:0]      w_ext;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout;

    function automatic logic f_op_legal(input logic [2:0] f_op);
        return (f_op == OP_LB) || (f_op == OP_LH) || (f_op == OP_LW) ||
               (f_op == OP_LBU) || (f_op == OP_LHU);
    endfunction

    // Halfwords need an even address and words need a multiple of four.
    // Bytes are never misaligned.
    function automatic logic f_misaligned(input logic [2:0] f_op, input logic [1:0] f_off);
        logic v_mis;
        v_mis = 1'b0;
        if (f_op == OP_LH || f_op == OP_LHU)
            v_mis = f_off[0];
        else if (f_op == OP_LW)
            v_mis = (f_off != 2'b00);
        return v_mis;
    endfunction

    // op[1:0] encodes the access size: 00 byte, 01 half, 11 word.
    function automatic logic [3:0] f_byteenable(input logic [2:0] f_op, input logic [1:0] f_off);
        logic [3:0] v_be;
        case (f_op[1:0])
            2'b00:   v_be = 4'b0001 << f_off;
            2'b01:   v_be = f_off[1] ? 4'b1100 : 4'b0011;
            default: v_be = 4'b1111;
        endcase
        return v_be;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] f_extend(input logic [2:0] f_op, input logic [1:0] f_off,
                                             input logic [31:0] f_word);
        logic [7:0]  v_b;
        logic [15:0] v_h;
        logic [31:0] v_r;
        case (f_off)
            2'd0:    v_b = f_word[7:0];
            2'd1:    v_b = f_word[15:8];
            2'd2:    v_b = f_word[23:16];
            default: v_b = f_word[31:24];
        endcase
        v_h = f_off[1] ? f_word[31:16] : f_word[15:0];
        case (f_op)
            OP_LB:   v_r = {{24{v_b[7]}}, v_b};
            OP_LBU:  v_r = {24'd0, v_b};
            OP_LH:   v_r = {{16{v_h[15]}}, v_h};
            OP_LHU:  v_r = {16'd0, v_h};
            default: v_r = f_word;
        endcase
        return v_r;
    endfunction

    // Request decode and read-data formatting for the current cycle
    always_comb begin
        w_req_ok   = f_op_legal(op) && !f_misaligned(op, addr[1:0]);
        w_be       = f_byteenable(op, addr[1:0]);
        w_ext      = f_extend(r_op, r_off, mem_readdata);
        w_cnt_next = r_cnt + 1'b1;
        w_timeout  = (MAX_WAIT != 0) && (w_cnt_next == MAX_WAIT_C);
    end

    // Load FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_op             <= 3'd0;
            r_off            <= 2'd0;
            r_cnt            <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_rdata          <= 32'd0;
            r_addr_err       <= 1'b0;
            r_bus_err        <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_address    <= 32'd0;
            r_mem_byteenable <= 4'd0;
        end else begin
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_req_ok) begin
                            r_state          <= READ;
                            r_op             <= op;
                            r_off            <= addr[1:0];
                            r_mem_address    <= {addr[31:2], 2'b00};
                            r_mem_byteenable <= w_be;
                            r_mem_read       <= 1'b1;
                            r_busy           <= 1'b1;
                            r_cnt            <= '0;
                        end else begin
                            // Rejected requests never reach the bus.
                            r_state    <= ERR;
                            r_done     <= 1'b1;
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (!mem_waitrequest) begin
                        r_state    <= DONE;
                        r_rdata    <= w_ext;
                        r_mem_read <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_timeout) begin
                            // rdata keeps its previous value on a bus timeout.
                            r_state    <= ERR;
                            r_mem_read <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_bus_err  <= 1'b1;
                        end
                    end
                end
                // start is ignored in both strobe states and is only accepted back in IDLE.
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign rdata          = r_rdata;
    assign addr_err       = r_addr_err;
    assign bus_err        = r_bus_err;
    assign mem_read       = r_mem_read;
    assign mem_address    = r_mem_address;
    assign mem_byteenable = r_mem_byteenable;

endmodule
